// File: rtl/lv_owt_pkg.sv
// Shared types for the LV one-wire transmit arbiter: FSM state encoding,
// request-source codes and the default frame width.
package lv_owt_pkg;

  localparam int FRM_W_DFLT = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_t;

  localparam logic [1:0] SRC_FLT  = 2'd0;
  localparam logic [1:0] SRC_SPI  = 2'd1;
  localparam logic [1:0] SRC_POLL = 2'd2;

endpackage

// File: rtl/lv_owt_poll_tmr.sv
// Periodic poll timer: free-runs while enabled and raises a sticky pending
// flag every POLL_PERIOD cycles; the flag drops when the poll frame is taken.
module lv_owt_poll_tmr #(
  parameter int POLL_PERIOD = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_pend
);

  localparam int CW = $clog2(POLL_PERIOD);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt    <= '0;
      o_pend <= 1'b0;
    end else if (!i_en) begin
      cnt    <= '0;
      o_pend <= 1'b0;
    end else if (cnt == CW'(POLL_PERIOD - 1)) begin
      // A new period beats a same-cycle clear so no poll interval is lost.
      cnt    <= '0;
      o_pend <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (i_clr) o_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/lv_owt_arb.sv
// LV one-wire transmit arbiter: shares the OWT tx path between fault-clear,
// SPI and periodic poll sources. Poll source built only with LV_OWT_ARB_POLL_EN.
module lv_owt_arb
  import lv_owt_pkg::*;
#(
  parameter int               FRM_W       = FRM_W_DFLT,
  parameter int               POLL_PERIOD = 1000,
  parameter logic [FRM_W-1:0] POLL_FRM    = FRM_W'(16'h8000),
  parameter int               RSP_TOUT    = 255,
  parameter int               STARVE_MAX  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flt_req,
  input  logic [FRM_W-1:0] i_flt_frm,
  output logic             o_flt_gnt,
  input  logic             i_spi_req,
  input  logic [FRM_W-1:0] i_spi_frm,
  output logic             o_spi_gnt,
  input  logic             i_poll_en,
  output logic             o_tx_vld,
  output logic [FRM_W-1:0] o_tx_frm,
  input  logic             i_tx_rdy,
  input  logic             i_rx_vld,
  input  logic [FRM_W-1:0] i_rx_frm,
  output logic             o_rsp_vld,
  output logic [FRM_W-1:0] o_rsp_frm,
  output logic [1:0]       o_rsp_src,
  output logic             o_rsp_tout,
  output logic [7:0]       o_tout_cnt,
  output logic             o_busy,
  output state_t           o_dbg_state
);

  localparam int TW = (RSP_TOUT > 1) ? $clog2(RSP_TOUT) : 1;

  state_t           state;
  logic [1:0]       src_q;
  logic [TW-1:0]    tmr;
  logic             hs;
  logic             poll_pend;
  logic             starve_full;
  logic             poll_win;
  logic             sel_vld;
  logic [1:0]       sel_src;
  logic [FRM_W-1:0] sel_frm;

  // valid/ready: a frame transfers in the cycle o_tx_vld & i_tx_rdy; until then
  // o_tx_vld stays high and o_tx_frm holds the latched frame.
  assign hs          = o_tx_vld & i_tx_rdy;
  assign o_flt_gnt   = hs & (src_q == SRC_FLT);
  assign o_spi_gnt   = hs & (src_q == SRC_SPI);
  assign o_dbg_state = state;

`ifdef LV_OWT_ARB_POLL_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          poll_clr;

  assign poll_clr = hs & (src_q == SRC_POLL);

  lv_owt_poll_tmr #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_poll_tmr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_poll_en),
    .i_clr  (poll_clr),
    .o_pend (poll_pend)
  );

  // Counts SPI grants taken while a poll is waiting; saturates at STARVE_MAX.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (!poll_pend || poll_clr) begin
      starve_cnt <= '0;
    end else if (o_spi_gnt && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign starve_full = (starve_cnt == SW'(STARVE_MAX));
`else
  logic [31:0] cfg_unused;

  assign poll_pend   = 1'b0;
  assign starve_full = 1'b0;
  assign cfg_unused  = {31'h0, i_poll_en} ^ 32'(POLL_PERIOD) ^ 32'(STARVE_MAX);
`endif

  assign poll_win = poll_pend & (~i_spi_req | starve_full);

  always_comb begin
    sel_vld = 1'b0;
    sel_src = SRC_FLT;
    sel_frm = i_flt_frm;
    if (i_flt_req) begin
      sel_vld = 1'b1;
    end else if (poll_win) begin
      sel_vld = 1'b1;
      sel_src = SRC_POLL;
      sel_frm = POLL_FRM;
    end else if (i_spi_req) begin
      sel_vld = 1'b1;
      sel_src = SRC_SPI;
      sel_frm = i_spi_frm;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      src_q      <= SRC_FLT;
      tmr        <= '0;
      o_tx_vld   <= 1'b0;
      o_tx_frm   <= '0;
      o_rsp_vld  <= 1'b0;
      o_rsp_frm  <= '0;
      o_rsp_src  <= '0;
      o_rsp_tout <= 1'b0;
      o_tout_cnt <= '0;
      o_busy     <= 1'b0;
    end else begin
      o_rsp_vld  <= 1'b0;
      o_rsp_tout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_vld) begin
            state    <= ST_ISSUE;
            src_q    <= sel_src;
            o_tx_vld <= 1'b1;
            o_tx_frm <= sel_frm;
            o_busy   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (i_tx_rdy) begin
            state    <= ST_WAIT_RSP;
            o_tx_vld <= 1'b0;
            tmr      <= '0;
          end
        end
        ST_WAIT_RSP: begin
          // A response in the terminal cycle is taken instead of timing out.
          if (i_rx_vld) begin
            state     <= ST_IDLE;
            o_rsp_vld <= 1'b1;
            o_rsp_frm <= i_rx_frm;
            o_rsp_src <= src_q;
            o_busy    <= 1'b0;
          end else if (tmr == TW'(RSP_TOUT - 1)) begin
            state      <= ST_IDLE;
            o_rsp_tout <= 1'b1;
            o_rsp_src  <= src_q;
            o_busy     <= 1'b0;
            if (o_tout_cnt != 8'hFF) o_tout_cnt <= o_tout_cnt + 8'd1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          o_tx_vld <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
